// File: rtl/param_password_lock.sv
// rtl/param_password_lock.sv - N-digit keypad lock with debounced keys, fail counting and timed lockout
// Build macro PW_CHANGE_EN adds a user-settable password register and the SETPW state.

module ppl_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);
  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  // level_q is the debounced key level; it only follows sync2_q after CYCLES stable samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

module param_password_lock #(
  parameter int DIGITS          = 4,
  parameter int DIGIT_W         = 4,
  parameter int MAX_TRIES       = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SHOW_CYCLES     = 50000000,
  parameter int LOCKOUT_CYCLES  = 500000000
) (
  input  logic                        clk_50,
  input  logic                        rst,
  input  logic [DIGIT_W-1:0]          USERIN,
  input  logic                        KEY_ENTER,
  input  logic                        KEY_CLEAR,
  input  logic [DIGITS*DIGIT_W-1:0]   PASSWORD,
  output logic                        LEDR,
  output logic                        LEDG,
  output logic                        locked,
  output logic [3:0]                  tries_left,
  output logic [6:0]                  H0,
  output logic [6:0]                  H1,
  output logic [6:0]                  H2,
  output logic [6:0]                  H3
);
  localparam int PW   = DIGITS * DIGIT_W;
  localparam int CW   = $clog2(DIGITS + 1);
  localparam int TMAX = (SHOW_CYCLES > LOCKOUT_CYCLES) ? SHOW_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [6:0] SEG_BLANK = 7'h7F, SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_O = 7'b1000000, SEG_P = 7'b0001100, SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_N = 7'b0101011, SEG_F = 7'b0001110, SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_I = 7'b1111001, SEG_L = 7'b1000111, SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001, SEG_S = 7'b0010010, SEG_T = 7'b0000111;

`ifdef PW_CHANGE_EN
  typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT, ST_SETPW} state_t;
`else
  typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_FAIL, ST_LOCKOUT} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   buf_q, buf_d, shifted, pw_ref;
  logic [3:0]      fail_q, fail_d, tries_q, tries_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ledr_q, ledr_d, ledg_q, ledg_d, locked_q, locked_d;
  logic [6:0]      h_q [4];
  logic [6:0]      h_d [4];
  logic            enter_raw, clear_p, enter_p;

  ppl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk_i(clk_50), .rst_i(rst), .key_n_i(KEY_ENTER), .press_o(enter_raw));
  ppl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk_i(clk_50), .rst_i(rst), .key_n_i(KEY_CLEAR), .press_o(clear_p));

  assign enter_p = enter_raw & ~clear_p;
  assign shifted = {buf_q[PW-DIGIT_W-1:0], USERIN};

`ifdef PW_CHANGE_EN
  logic [PW-1:0] pw_q, pw_d;
  assign pw_ref = pw_q;
  always_ff @(posedge clk_50) begin
    if (rst) pw_q <= PASSWORD;
    else     pw_q <= pw_d;
  end
`else
  assign pw_ref = PASSWORD;
`endif

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q  <= ST_ENTRY;
      cnt_q    <= '0;
      buf_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      tries_q  <= 4'(MAX_TRIES);
      ledr_q   <= 1'b0;
      ledg_q   <= 1'b0;
      locked_q <= 1'b0;
      for (int k = 0; k < 4; k++) h_q[k] <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      tries_q  <= tries_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      locked_q <= locked_d;
      for (int k = 0; k < 4; k++) h_q[k] <= h_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    fail_d  = fail_q;
    timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
`ifdef PW_CHANGE_EN
    pw_d    = pw_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (clear_p) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (enter_p) begin
          buf_d = shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS - 1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        buf_d = '0;
        if (buf_q == pw_ref) begin
          fail_d  = '0;
          state_d = ST_OPEN;
          timer_d = TW'(SHOW_CYCLES - 1);
        end else begin
          fail_d = fail_q + 4'd1;
          if (fail_d == 4'(MAX_TRIES)) begin
            state_d = ST_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ST_FAIL;
            timer_d = TW'(SHOW_CYCLES - 1);
          end
        end
      end
      ST_OPEN: begin
        if (clear_p)              state_d = ST_ENTRY;
`ifdef PW_CHANGE_EN
        else if (enter_p)         state_d = ST_SETPW;
`endif
        else if (timer_q == '0)   state_d = ST_ENTRY;
      end
      ST_FAIL: begin
        if (timer_q == '0) state_d = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end
      end
`ifdef PW_CHANGE_EN
      ST_SETPW: begin
        timer_d = timer_q;
        if (clear_p) begin
          state_d = ST_ENTRY;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (enter_p) begin
          buf_d = shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DIGITS - 1)) begin
            pw_d    = shifted;
            state_d = ST_ENTRY;
            cnt_d   = '0;
            buf_d   = '0;
          end
        end
      end
`endif
      default: state_d = ST_ENTRY;
    endcase

    // Outputs are derived from the next state so the registered copies line up with state_q
    ledg_d   = (state_d == ST_OPEN);
    ledr_d   = (state_d == ST_FAIL) || (state_d == ST_LOCKOUT);
    locked_d = (state_d == ST_LOCKOUT);
    tries_d  = 4'(MAX_TRIES) - fail_d;
    for (int k = 0; k < 4; k++) h_d[k] = (k < int'(cnt_d)) ? SEG_DASH : SEG_BLANK;
    case (state_d)
      ST_OPEN:    begin h_d[3] = SEG_O; h_d[2] = SEG_P; h_d[1] = SEG_E; h_d[0] = SEG_N; end
      ST_FAIL:    begin h_d[3] = SEG_F; h_d[2] = SEG_A; h_d[1] = SEG_I; h_d[0] = SEG_L; end
      ST_LOCKOUT: begin h_d[3] = SEG_L; h_d[2] = SEG_O; h_d[1] = SEG_C; h_d[0] = SEG_D; end
`ifdef PW_CHANGE_EN
      ST_SETPW:   begin h_d[3] = SEG_S; h_d[2] = SEG_E; h_d[1] = SEG_T; h_d[0] = SEG_DASH; end
`endif
      default: ;
    endcase
  end

  assign LEDR       = ledr_q;
  assign LEDG       = ledg_q;
  assign locked     = locked_q;
  assign tries_left = tries_q;
  assign H0         = h_q[0];
  assign H1         = h_q[1];
  assign H2         = h_q[2];
  assign H3         = h_q[3];
endmodule
